// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per valid/ready transaction, byte-lane stores,
// sign/zero-extended loads and a single response pulse after WAIT_CYCLES stall cycles.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        we_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the access happens on the acceptance edge itself,
    // so decode from the live bus in IDLE and from the captured copy afterwards.
    logic        cur_we, cur_uns;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    assign cur_we    = (state == S_IDLE) ? bus.req_we       : we_q;
    assign cur_uns   = (state == S_IDLE) ? bus.req_unsigned : uns_q;
    assign cur_addr  = (state == S_IDLE) ? bus.req_addr     : addr_q;
    assign cur_wdata = (state == S_IDLE) ? bus.req_wdata    : wdata_q;
    assign cur_size  = (state == S_IDLE) ? bus.req_size     : size_q;

    assign accept = (state == S_IDLE) && bus.req_valid;

    logic [29:0]      offset_w;
    logic [IDX_W-1:0] word_idx;
    logic             in_range, err;
    logic [3:0]       be;
    logic [31:0]      wdata_rep, word, load_data;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    assign offset_w = cur_addr[31:2] - ADDR_BASE[31:2];
    assign word_idx = offset_w[IDX_W-1:0];
    assign in_range = (cur_addr >= ADDR_BASE) && ({2'b00, offset_w} < DEPTH_WORDS);
    assign word     = mem[word_idx];
    assign lane_b   = 8'(word >> {cur_addr[1:0], 3'b000});
    assign lane_h   = cur_addr[1] ? word[31:16] : word[15:0];

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        err       = !in_range;
        be        = 4'b0000;
        wdata_rep = cur_wdata;
        load_data = word;
        case (cur_size)
            2'b00: begin
                be        = 4'b0001 << cur_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
                load_data = cur_uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            2'b01: begin
                err       = err | cur_addr[0];
                be        = 4'b0011 << {cur_addr[1], 1'b0};
                wdata_rep = {2{cur_wdata[15:0]}};
                load_data = cur_uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            2'b10: begin
                err = err | (cur_addr[1:0] != 2'b00);
                be  = 4'b1111;
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        next_state     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT:  if (cnt <= 4'd1) next_state = S_RESP;
            S_RESP: begin
                bus.resp_valid = 1'b1;
                next_state     = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
        end else begin
            state <= next_state;
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                cnt     <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (next_state == S_RESP && state != S_RESP) begin
                rdata_q <= (cur_we || err) ? 32'h0 : load_data;
                err_q   <= err;
            end
        end
    end

    // NOTE: the array has no reset; contents survive reset and only a request reaching RESP writes it.
    always_ff @(posedge clk) begin
        if (!reset && next_state == S_RESP && state != S_RESP && cur_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid0 = 1'b0, valid3 = 1'b0;
    logic        we = 1'b0, uns = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [1:0]  size = 2'b10;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus3 ();

    assign bus0.req_valid = valid0;
    assign bus0.req_we = we;
    assign bus0.req_addr = addr;
    assign bus0.req_size = size;
    assign bus0.req_unsigned = uns;
    assign bus0.req_wdata = wdata;
    assign bus3.req_valid = valid3;
    assign bus3.req_we = we;
    assign bus3.req_addr = addr;
    assign bus3.req_size = size;
    assign bus3.req_unsigned = uns;
    assign bus3.req_wdata = wdata;

    dmem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    dmem_responder #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? bus0.req_ready : bus3.req_ready;
    endfunction
    function automatic logic rvalid_of(input int sel);
        return (sel == 0) ? bus0.resp_valid : bus3.resp_valid;
    endfunction
    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? bus0.resp_rdata : bus3.resp_rdata;
    endfunction
    function automatic logic err_of(input int sel);
        return (sel == 0) ? bus0.resp_err : bus3.resp_err;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid0 = v;
        else valid3 = v;
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        while (ready_of(sel) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Runs one transaction; returns latency in cycles, response fields, req_ready during
    // the response cycle and resp_valid on the cycle after it.
    task automatic issue(input int sel, input vec_t v, output int lat, output logic [31:0] rd,
                         output logic er, output logic rdy, output logic pulse_after);
        @(negedge clk);
        we = v.we; addr = v.addr; size = v.size; uns = v.uns; wdata = v.wdata;
        set_valid(sel, 1'b1);
        wait_ready(sel);
        @(posedge clk);
        @(negedge clk);
        set_valid(sel, 1'b0);
        lat = 1;
        while (rvalid_of(sel) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd  = rdata_of(sel);
        er  = err_of(sel);
        rdy = ready_of(sel);
        @(negedge clk);
        pulse_after = rvalid_of(sel);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            logic [34:0] obs;
            obs = {ready_of(s), rvalid_of(s), err_of(s), rdata_of(s)};
            checks++;
            if (obs !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
                failures++;
                $display("FAIL reset_state dut%0d got rdy/vld/err/rdata=%h required=%h", s, obs,
                         {1'b1, 1'b0, 1'b0, 32'h0});
            end
        end
    endtask

    task automatic run_table(input string name, input int sel, input vec_t v [], input int exp_lat);
        foreach (v[i]) begin
            int lat; logic [31:0] rd; logic er, rdy, pl;
            logic [39:0] obs, expv;
            issue(sel, v[i], lat, rd, er, rdy, pl);
            obs  = {rdy, pl, er, lat[4:0], rd};
            expv = {1'b0, 1'b0, v[i].err, 5'(exp_lat), v[i].rdata};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL %s[%0d] addr=%h got rdy,pulse,err,lat,rdata=%h required=%h",
                         name, i, v[i].addr, obs, expv);
            end
        end
    endtask

    task automatic test_word_round_trip();
        vec_t v [] = new[2];
        v[0] = '{1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0};
        v[1] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0};
        run_table("round_trip", 0, v, 1);
    endtask

    task automatic test_lanes();
        vec_t v [] = new[8];
        v[0] = '{1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_0080, 32'h0, 1'b0};
        v[1] = '{1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0};
        v[2] = '{1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h0000_0080, 1'b0};
        v[3] = '{1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0};
        v[4] = '{1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 32'h0000_80EF, 1'b0};
        v[5] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0};
        v[6] = '{1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0};
        v[7] = '{1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 32'hDEAD_80EF, 1'b0};
        run_table("lanes", 0, v, 1);
    endtask

    task automatic test_errors();
        vec_t v [] = new[7];
        v[0] = '{1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1};
        v[1] = '{1'b1, 32'h12, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1};
        v[2] = '{1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1};
        v[3] = '{1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1};
        v[4] = '{1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1};
        v[5] = '{1'b1, 32'h11, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1};
        v[6] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0};
        run_table("errors", 0, v, 1);
    endtask

    task automatic test_back_to_back();
        vec_t v [] = new[2];
        logic [4:0] rdy_hist, vld_hist;
        logic [31:0] first_rd;
        int lat;
        v[0] = '{1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0};
        v[1] = '{1'b1, 32'h24, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0};
        run_table("wait_preload", 1, v, 4);

        @(negedge clk);
        we = 1'b0; addr = 32'h20; size = 2'b10; uns = 1'b0;
        valid3 = 1'b1;
        wait_ready(1);
        @(posedge clk);
        first_rd = 32'hX;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rdy_hist[k] = bus3.req_ready;
            vld_hist[k] = bus3.resp_valid;
            if (k == 3) first_rd = bus3.resp_rdata;
        end
        checks++;
        if ({rdy_hist, vld_hist, first_rd} !== {5'b10000, 5'b01000, 32'h0}) begin
            failures++;
            $display("FAIL b2b_first ready_hist=%b valid_hist=%b rdata=%h required 10000 01000 00000000",
                     rdy_hist, vld_hist, first_rd);
        end
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        lat = 1;
        while (bus3.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({lat[4:0], bus3.resp_err, bus3.resp_rdata} !== {5'd4, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL b2b_second lat=%0d err=%b rdata=%h required lat=4 err=0 rdata=0",
                     lat, bus3.resp_err, bus3.resp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        vec_t v [] = new[1];
        logic seen;
        @(negedge clk);
        we = 1'b1; addr = 32'h20; size = 2'b10; uns = 1'b0; wdata = 32'h1234_5678;
        valid3 = 1'b1;
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus3.req_ready, bus3.resp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_state ready=%b resp_valid=%b required ready=1 resp_valid=0",
                     bus3.req_ready, bus3.resp_valid);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus3.resp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_resp resp_valid seen=%b required 0", seen);
        end
        v[0] = '{1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0};
        run_table("reset_mid_readback", 1, v, 4);
    endtask

    task automatic test_handshake_hold();
        vec_t v [] = new[1];
        int n;
        @(negedge clk);
        we = 1'b1; addr = 32'h24; size = 2'b10; uns = 1'b0; wdata = 32'h1111_1111;
        valid3 = 1'b1;
        wait_ready(1);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            wdata = 32'hA000_0000 + 32'(k);
        end
        @(negedge clk);
        wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        wdata = 32'hBAD0_BAD0;
        valid3 = 1'b0;
        n = 0;
        while (bus3.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        v[0] = '{1'b0, 32'h24, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0};
        run_table("hold_readback", 1, v, 4);
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_handshake_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
